// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage MIPS core. Handles the
// hazards the EX-stage forwarding network cannot: load-use stalls,
// taken-branch / jump flushes and multi-cycle mult/div (MDU) occupancy.
//
// Parameters
//   MDU_LATENCY  EX cycles a mult/div occupies (2..15).
//   CNT_W        MDU cycle counter width, 2**CNT_W > MDU_LATENCY.
//
// Ports
//   clk            in   core clock, rising edge
//   reset          in   synchronous reset, active low
//   ID_EX_MemRead  in   instruction in EX is a load
//   ID_EX_Rt       in   destination register of that load
//   IF_ID_Rs       in   source Rs of the instruction in ID
//   IF_ID_Rt       in   source Rt of the instruction in ID
//   Jump           in   J/JAL/JR decoded in ID
//   BranchTaken    in   branch resolved taken in MEM
//   MDU_Start      in   mult/div entering EX this cycle
//   PCWrite        out  PC load enable
//   IF_ID_Write    out  IF/ID load enable
//   IF_ID_Flush    out  IF/ID cleared to NOP
//   ID_EX_Write    out  ID/EX load enable
//   ID_EX_Bubble   out  ID/EX control fields zeroed
//   EX_MEM_Bubble  out  EX/MEM control fields zeroed
//   MDU_Busy       out  MDU operation in progress (registered; this is the
//                       FSM state bit, 1 = MDU_BUSY)
//   MDU_Abort      out  one-cycle pulse, in-flight MDU op cancelled
//
// Optional build macro HAZARD_STATS_EN adds two saturating 16-bit counters:
//   stall_cycles   out  cycles with PCWrite == 0
//   flush_events   out  cycles with IF_ID_Flush == 1

module hazard_stall_controller #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       Jump,
  input  logic       BranchTaken,
  input  logic       MDU_Start,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Write,
  output logic       ID_EX_Bubble,
  output logic       EX_MEM_Bubble,
  output logic       MDU_Busy,
  output logic       MDU_Abort
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             abort_next;
  logic             load_use;

  // A load into $zero never creates a real dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // State register doubles as the MDU_Busy output, so the FSM state is
  // directly observable at the port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      MDU_Abort <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      MDU_Abort <= abort_next;
    end
  end

  assign MDU_Busy = (state == MDU_BUSY);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    abort_next    = 1'b0;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;

    if (BranchTaken) begin
      // Taken branch squashes everything younger, including a mult/div that
      // is in flight or just starting; the PC takes the branch target.
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
      state_next    = IDLE;
      cnt_next      = '0;
      abort_next    = (state == MDU_BUSY);
    end else begin
      unique case (state)
        IDLE: begin
          if (load_use) begin
            // Stall wins over Jump: the jump sits in ID and must not be
            // flushed while IF/ID is being held.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (Jump) begin
            IF_ID_Flush = 1'b1;
          end
          if (MDU_Start) begin
            state_next = MDU_BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        MDU_BUSY: begin
          // Whole front end frozen; hazards in ID are re-evaluated once
          // we are back in IDLE. The last busy cycle lets the result
          // through into EX/MEM.
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = (cnt != CNT_ONE);
          cnt_next      = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!PCWrite && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (IF_ID_Flush && (flush_events != 16'hFFFF)) begin
        flush_events <= flush_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
  logic       Jump, BranchTaken, MDU_Start;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
  logic       ID_EX_Bubble, EX_MEM_Bubble, MDU_Busy, MDU_Abort;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  always #5 clk = ~clk;

  hazard_stall_controller #(.MDU_LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs),
    .IF_ID_Rt(IF_ID_Rt),
    .Jump(Jump),
    .BranchTaken(BranchTaken),
    .MDU_Start(MDU_Start),
    .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write),
    .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Bubble(EX_MEM_Bubble),
    .MDU_Busy(MDU_Busy),
    .MDU_Abort(MDU_Abort)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  // ---------------- reference model ----------------
  // m_freeze: number of frozen cycles still owed to an in-flight mult/div.
  int n_checks = 0;
  int n_errors = 0;
  int m_freeze = 0;
  bit m_abort  = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver + scoreboard step ----------------
  task automatic step(input bit rst_n, input bit mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input bit j, input bit bt, input bit ms);
    bit lu;
    bit e_pc, e_ifw, e_fl, e_idw, e_idb, e_exb;
    @(negedge clk);
    reset = rst_n; ID_EX_MemRead = mr; ID_EX_Rt = ert;
    IF_ID_Rs = rs; IF_ID_Rt = rt; Jump = j; BranchTaken = bt; MDU_Start = ms;
    #1;
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    {e_pc, e_ifw, e_fl, e_idw, e_idb, e_exb} = 6'b110100;
    if (bt) begin
      e_fl = 1; e_idb = 1; e_exb = 1;
    end else if (m_freeze > 0) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exb = (m_freeze != 1);
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_idb = 1;
    end else if (j) begin
      e_fl = 1;
    end
    check_bit("PCWrite",       PCWrite,       e_pc);
    check_bit("IF_ID_Write",   IF_ID_Write,   e_ifw);
    check_bit("IF_ID_Flush",   IF_ID_Flush,   e_fl);
    check_bit("ID_EX_Write",   ID_EX_Write,   e_idw);
    check_bit("ID_EX_Bubble",  ID_EX_Bubble,  e_idb);
    check_bit("EX_MEM_Bubble", EX_MEM_Bubble, e_exb);
    check_bit("MDU_Busy",      MDU_Busy,      m_freeze > 0);
    check_bit("MDU_Abort",     MDU_Abort,     m_abort);
`ifdef HAZARD_STATS_EN
    check_word("stall_cycles", stall_cycles, 16'(m_stall));
    check_word("flush_events", flush_events, 16'(m_flush));
`endif
    // advance model to the next clock edge
    if (!rst_n) begin
      m_freeze = 0; m_abort = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < 16'hFFFF) m_stall++;
      if (e_fl && m_flush < 16'hFFFF) m_flush++;
      m_abort = (m_freeze > 0) && bt;
      if (m_freeze > 0) m_freeze = bt ? 0 : m_freeze - 1;
      else if (ms && !bt) m_freeze = LAT - 1;
    end
  endtask

  task automatic idle_step();
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 0; ID_EX_MemRead = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
    Jump = 0; BranchTaken = 0; MDU_Start = 0;
    // reset, then default vector out of reset
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle_step();
    // load-use on Rs, single stall cycle then bubble clears MemRead
    step(1, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    step(1, 0, 5'd0, 5'd8, 5'd3, 0, 0, 0);
    // load-use on Rt
    step(1, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0);
    idle_step();
    // load to $zero
    step(1, 1, 5'd0, 5'd4, 5'd0, 0, 0, 0);
    // jump
    step(1, 0, 5'd0, 5'd1, 5'd2, 1, 0, 0);
    // full MDU occupancy, start repeated while busy is ignored
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1);
    step(1, 1, 5'd5, 5'd5, 5'd2, 1, 0, 1);
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    idle_step();
    // abort in MDU cycle 2
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1);
    idle_step();
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0);
    idle_step();
    idle_step();
    // branch priority over jump + load-use
    step(1, 1, 5'd7, 5'd7, 5'd7, 1, 1, 0);
    // MDU_Start squashed by BranchTaken
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1);
    idle_step();
    // reset in MDU cycle 1
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1);
    step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    idle_step();
    idle_step();
    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
